// File: rtl/pattern_serializer.sv
// Serial bit-pattern transmitter: captures pattern/len/repeat on start and emits it MSB-first,
// one bit per clock, for repeat_n+1 back-to-back passes, with a 5-bit history of sent bits.
module pattern_serializer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] repeat_n,
  output logic             x,
  output logic [4:0]       out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  // Handshake: start is a level request sampled only on an IDLE edge; busy is high for exactly
  // the cycles a frame bit is on x; done pulses for one cycle after the last bit, then IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
  localparam logic [REP_W-1:0] ONE_P   = REP_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] leff_q, leff_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic             x_q, x_d;
  logic [4:0]       out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] leff_in;
  logic [WIDTH-1:0] in_first_shift;
  logic [WIDTH-1:0] q_next_shift;
  logic [WIDTH-1:0] q_first_shift;
  logic             first_in;
  logic             next_bit;
  logic             first_q;
  logic             last_bit;
  logic             more_passes;

  // idx_q is the index of the bit currently on x, so index 0 marks the end of a pass.
  assign leff_in        = ((len == '0) || (len > WIDTH_L)) ? WIDTH_L : len;
  assign in_first_shift = pattern >> (leff_in - ONE_L);
  assign q_next_shift   = pat_q >> (idx_q - ONE_L);
  assign q_first_shift  = pat_q >> (leff_q - ONE_L);
  assign first_in       = in_first_shift[0];
  assign next_bit       = q_next_shift[0];
  assign first_q        = q_first_shift[0];
  assign last_bit       = (idx_q == '0);
  assign more_passes    = (pass_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      leff_q  <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      x_q     <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      leff_q  <= leff_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      x_q     <= x_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SEND;
      S_SEND:  if (last_bit && !more_passes) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pat_d  = pat_q;
    leff_d = leff_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    x_d    = 1'b0;
    out_d  = out_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d  = pattern;
          leff_d = leff_in;
          idx_d  = leff_in - ONE_L;
          pass_d = repeat_n;
          x_d    = first_in;
          out_d  = {4'b0000, first_in};
          busy_d = 1'b1;
        end
      end
      S_SEND: begin
        if (!last_bit) begin
          idx_d  = idx_q - ONE_L;
          x_d    = next_bit;
          out_d  = {out_q[3:0], next_bit};
          busy_d = 1'b1;
        end else if (more_passes) begin
          // Next pass starts on the very next edge, no idle gap.
          idx_d  = leff_q - ONE_L;
          pass_d = pass_q - ONE_P;
          x_d    = first_q;
          out_d  = {out_q[3:0], first_q};
          busy_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign x       = x_q;
  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: per-cycle comparison against a frame-level model, plus directed
// frames with literal expectations, asynchronous reset checks and randomized traffic.
module tb_pattern_serializer;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int REP_W = 4;
  localparam int EW    = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] pattern = '0;
  logic [LEN_W-1:0] len = '0;
  logic [REP_W-1:0] repeat_n = '0;
  logic             x;
  logic [4:0]       out;
  logic             busy;
  logic             done;
  logic [1:0]       state_o;

  int total = 0;
  int bad   = 0;

  pattern_serializer #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W),
    .REP_W(REP_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .repeat_n(repeat_n),
    .x       (x),
    .out     (out),
    .busy    (busy),
    .done    (done),
    .state_o (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  // entry layout: {state(2), done, busy, x, out[4:0]}; state 0 idle, 1 sending, 2 done
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_cur = '0;
  logic          model_idle = 1'b1;

  function automatic logic [EW-1:0] pack(input logic [1:0] st, input logic dn, input logic bz,
                                         input logic xb, input logic [4:0] o);
    return {st, dn, bz, xb, o};
  endfunction

  task automatic model_load(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                            input logic [REP_W-1:0] r);
    int leff;
    logic [4:0] h;
    logic b;
    leff = ((l == 0) || (int'(l) > WIDTH)) ? WIDTH : int'(l);
    h = '0;
    for (int ps = 0; ps <= int'(r); ps++) begin
      for (int i = leff - 1; i >= 0; i--) begin
        b = p[i];
        h = {h[3:0], b};
        exp_q.push_back(pack(2'd1, 1'b0, 1'b1, b, h));
      end
    end
    exp_q.push_back(pack(2'd2, 1'b1, 1'b0, 1'b0, h));
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      exp_cur    = '0;
      model_idle = 1'b1;
    end else begin
      if (model_idle && start) model_load(pattern, len, repeat_n);
      if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
      else exp_cur = pack(2'd0, 1'b0, 1'b0, 1'b0, exp_cur[4:0]);
      model_idle = !exp_cur[7] && !exp_cur[6];
    end
  end

  always @(negedge clk) begin
    total++;
    if ({state_o, done, busy, x, out} !== exp_cur) begin
      bad++;
      $display("FAIL cyc_cmp t=%0t got st=%0d done=%b busy=%b x=%b out=%b exp st=%0d done=%b busy=%b x=%b out=%b",
               $time, state_o, done, busy, x, out, exp_cur[9:8], exp_cur[7], exp_cur[6], exp_cur[5],
               exp_cur[4:0]);
    end
  end

  // ---------------- driver / directed helpers ----------------
  logic [63:0] xs, bs, ds;
  logic [4:0]  out_at[0:63];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [REP_W-1:0] r, input int ncyc, input bit hold_start,
                           input bit disturb);
    @(negedge clk);
    pattern  = p;
    len      = l;
    repeat_n = r;
    start    = 1'b1;
    xs = '0;
    bs = '0;
    ds = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      xs = {xs[62:0], x};
      bs = {bs[62:0], busy};
      ds = {ds[62:0], done};
      out_at[c] = out;
      if (!hold_start && c == 1) start = 1'b0;
      if (disturb && c == 4) begin
        start    = 1'b1;
        pattern  = 16'hFFFF;
        len      = 5'd3;
        repeat_n = 4'd7;
      end
      if (disturb && c == 8) start = 1'b0;
    end
    start = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    // reset held with clock running
    #6;
    check("rst_a", 64'({x, busy, done, out}), 64'(0));
    #5;
    check("rst_b", 64'({x, busy, done, out}), 64'(0));
    #5;
    check("rst_c", 64'({x, busy, done, out}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // 10101, single pass
    run_frame(16'b10101, 5'd5, 4'd0, 7, 1'b0, 1'b0);
    check("t2_x",    64'(xs[6:0]), 64'(7'b1010100));
    check("t2_busy", 64'(bs[6:0]), 64'(7'b1111100));
    check("t2_done", 64'(ds[6:0]), 64'(7'b0000010));
    check("t2_out5", 64'(out_at[5]), 64'(5'b10101));

    // 10 repeated three times
    run_frame(16'b10, 5'd2, 4'd2, 8, 1'b0, 1'b0);
    check("t3_x",    64'(xs[7:0]), 64'(8'b10101000));
    check("t3_busy", 64'(bs[7:0]), 64'(8'b11111100));
    check("t3_done", 64'(ds[7:0]), 64'(8'b00000010));
    check("t3_out6", 64'(out_at[6]), 64'(5'b01010));

    // len 0 and len 20 both mean full width; mid-frame input changes ignored
    run_frame(16'hA5C3, 5'd0, 4'd0, 18, 1'b0, 1'b1);
    check("t4a_x",    64'(xs[17:0]), 64'({16'hA5C3, 2'b00}));
    check("t4a_done", 64'(ds[17:0]), 64'(18'b10));
    run_frame(16'hA5C3, 5'd20, 4'd0, 18, 1'b0, 1'b1);
    check("t4b_x",    64'(xs[17:0]), 64'({16'hA5C3, 2'b00}));
    check("t4b_busy", 64'(bs[17:0]), 64'({16'hFFFF, 2'b00}));

    // start held high: done and idle cycles separate back-to-back frames
    run_frame(16'b110, 5'd3, 4'd0, 10, 1'b1, 1'b0);
    check("t5_x",    64'(xs[9:0]), 64'(10'b1100011000));
    check("t5_done", 64'(ds[9:0]), 64'(10'b0001000010));

    // asynchronous reset during bit 3 of a frame
    @(negedge clk);
    pattern  = 16'h00F0;
    len      = 5'd8;
    repeat_n = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_pre_x",   64'(x), 64'(1));
    check("t6_pre_out", 64'(out), 64'(5'b00111));
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_now", 64'({x, busy, done, out}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_stay_idle", 64'({busy, x, state_o}), 64'(0));

    // randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 5) == 0);
      pattern  = 16'($urandom());
      len      = 5'($urandom_range(0, 20));
      repeat_n = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if (c == 2000) begin
        #2;
        reset = 1'b1;
        #4;
        reset = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
